// File: rtl/sar_pkg.sv
// sar_pkg: shared types and constants for the SAR sequencer.
//   sar_state_e  - sequencer FSM states (IDLE / START / WAIT)
//   ERR_*        - bit positions inside err_o
//   acc_width()  - accumulator width needed to sum 2^osr_log2 results
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } sar_state_e;

  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_OVERRUN = 0;
  localparam int unsigned ERR_MISS    = 1;
  localparam int unsigned ERR_TIMEOUT = 2;

  // Summing 2^osr_log2 values of resolution bits needs osr_log2 extra bits.
  function automatic int unsigned acc_width(input int unsigned resolution,
                                            input int unsigned osr_log2);
    return resolution + osr_log2;
  endfunction

endpackage

// File: rtl/sar_tick_timer.sv
// sar_tick_timer: periodic trigger generator.
//   clk_i    - clock
//   rst_i    - asynchronous, active-high reset
//   en_i     - enable; while low the timer is held at zero
//   period_i - tick interval minus one, in clk cycles
//   tick_o   - one-cycle trigger (combinational from timer and en_i)
module sar_tick_timer #(
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic                    tick_o
);

  logic [PERIOD_WIDTH-1:0] timer_q;

  // Holding the timer at zero while disabled makes the first tick land on
  // the very first enabled cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else if (!en_i) begin
      timer_q <= '0;
    end else if (timer_q == '0) begin
      timer_q <= period_i;
    end else begin
      timer_q <= timer_q - PERIOD_WIDTH'(1);
    end
  end

  assign tick_o = en_i && (timer_q == '0);

endmodule

// File: rtl/sar_sequencer.sv
// sar_sequencer: triggers the SAR converter periodically, averages
// 2^OSR_LOG2 results per sample and presents them on a valid/ready stream.
//   clk_i, rst_i      - clock, asynchronous active-high reset
//   en_i, period_i    - periodic trigger enable and interval minus one
//   clr_i             - clears sticky err_o
//   start_o           - one-cycle conversion request
//   rdy_i, data_i     - converter done pulse and result
//   sample_o, valid_o - averaged sample stream, accepted with ready_i
//   err_o             - sticky {timeout, missed tick, overrun}
module sar_sequencer
  import sar_pkg::*;
#(
  parameter int unsigned RESOLUTION   = 12,
  parameter int unsigned OSR_LOG2     = 2,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic                    clr_i,
  output logic                    start_o,
  input  logic                    rdy_i,
  input  logic [RESOLUTION-1:0]   data_i,
  output logic [RESOLUTION-1:0]   sample_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [ERR_W-1:0]        err_o
);

  localparam int unsigned ACC_W = acc_width(RESOLUTION, OSR_LOG2);
  localparam int unsigned CNT_W = OSR_LOG2 + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << OSR_LOG2) - 1);
  // The START cycle counts toward the budget, so WAIT gives up after
  // TIMEOUT-1 silent cycles and the error shows TIMEOUT cycles after start_o.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

  logic tick;

  sar_tick_timer #(
    .PERIOD_WIDTH(PERIOD_WIDTH)
  ) u_tick_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .period_i(period_i),
    .tick_o  (tick)
  );

  sar_state_e              state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    start_q, start_d;
  logic [RESOLUTION-1:0]   sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic [ERR_W-1:0]        err_q, err_d;
  logic                    publish;

  // Next-state, accumulator, output register and error logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    err_d    = clr_i ? '0 : err_q;
    publish  = 1'b0;
    acc_sum  = acc_q + ACC_W'(data_i);

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rdy_i) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            publish = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_START;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d[ERR_TIMEOUT] = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    start_d = (state_d == ST_START);

    if (tick && (state_q != ST_IDLE)) begin
      err_d[ERR_MISS] = 1'b1;
    end

    // A held, unaccepted sample wins over a newly published one.
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (publish) begin
      if (valid_q && !ready_i) begin
        err_d[ERR_OVERRUN] = 1'b1;
      end else begin
        valid_d  = 1'b1;
        sample_d = RESOLUTION'(acc_sum >> OSR_LOG2);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      start_q  <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      start_q  <= start_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign start_o  = start_q;
  assign sample_o = sample_q;
  assign valid_o  = valid_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Testbench for sar_sequencer: default instance plus an OSR_LOG2=0 instance,
// each driven by a converter model answering RESOLUTION+1 cycles after start_o.
module tb_sar_sequencer;

  localparam int RES = 12;

  typedef struct {
    int sample;
    int cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] period;
  logic        clr;
  logic        ready;
  logic        start;
  logic        rdy_m;
  logic        rdy_force;
  logic        rdy_a;
  logic [11:0] data;
  logic [11:0] sample;
  logic        valid;
  logic [2:0]  err;

  logic        en0;
  logic        start0;
  logic        rdy0;
  logic [11:0] data0;
  logic [11:0] sample0;
  logic        valid0;
  logic [2:0]  err0;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic mute = 1'b0;
  int   cd = 0;
  int   conv_k = 0;
  int   cd0 = 0;
  exp_t exp_q[$];
  exp_t exp0_q[$];
  int   start_q[$];

  assign rdy_a = rdy_m || rdy_force;

  sar_sequencer dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .period_i(period),
    .clr_i   (clr),
    .start_o (start),
    .rdy_i   (rdy_a),
    .data_i  (data),
    .sample_o(sample),
    .valid_o (valid),
    .ready_i (ready),
    .err_o   (err)
  );

  sar_sequencer #(.OSR_LOG2(0)) dut0 (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en0),
    .period_i(period),
    .clr_i   (1'b0),
    .start_o (start0),
    .rdy_i   (rdy0),
    .data_i  (data0),
    .sample_o(sample0),
    .valid_o (valid0),
    .ready_i (1'b1),
    .err_o   (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: burst b returns 0x800+16b, +1, +2, +3 (average 0x801+16b).
  always @(negedge clk) begin
    rdy_m = 1'b0;
    if (rst) begin
      cd     = 0;
      conv_k = 0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          rdy_m  = 1'b1;
          data   = 12'(32'h800 + 16 * (conv_k / 4) + (conv_k % 4));
          conv_k = conv_k + 1;
        end
      end
      if (start && !mute) cd = RES + 1;
      if (start) start_q.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    rdy0 = 1'b0;
    if (rst) begin
      cd0 = 0;
    end else begin
      if (cd0 > 0) begin
        cd0 = cd0 - 1;
        if (cd0 == 0) begin
          rdy0  = 1'b1;
          data0 = 12'hFFF;
        end
      end
      if (start0) cd0 = RES + 1;
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard monitors: pop on every accepted sample.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_sample", int'(sample), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_sample", int'(sample), e.sample);
        chk("sb_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid0) begin
      if (exp0_q.size() == 0) begin
        chk("sb0_unexpected_sample", int'(sample0), -1);
      end else begin
        exp_t e;
        e = exp0_q.pop_front();
        chk("sb0_sample", int'(sample0), e.sample);
        chk("sb0_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int start_at(input int idx);
    if (idx < start_q.size()) return start_q[idx];
    return -1;
  endfunction

  task automatic push(input int s, input int c);
    exp_t e;
    e.sample = s;
    e.cyc    = c;
    exp_q.push_back(e);
  endtask

  task automatic clear_err();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("err_after_clr", int'(err), 0);
  endtask

  initial begin
    int t0;
    int s0;
    exp_t e0;
    rst = 1'b1; en = 1'b0; period = 16'd99; clr = 1'b0; ready = 1'b1;
    rdy_force = 1'b0; en0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", int'(start), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    goto(cyc + 5);

    // Basic burst: start pulses at T+1,+15,+29,+43; sample at T+57.
    t0 = cyc; s0 = start_q.size(); en = 1'b1;
    push('h801, t0 + 57);
    goto(t0 + 58);
    chk("p1_valid_one_cycle", int'(valid), 0);
    chk("p1_start0", start_at(s0) - t0, 1);
    chk("p1_start1", start_at(s0 + 1) - t0, 15);
    chk("p1_start2", start_at(s0 + 2) - t0, 29);
    chk("p1_start3", start_at(s0 + 3) - t0, 43);
    goto(t0 + 60); en = 1'b0;
    chk("p1_err", int'(err), 0);
    goto(t0 + 120);
    chk("p1_start_count", start_q.size() - s0, 4);

    // Backpressure: first sample held, second publish overruns.
    t0 = cyc; ready = 1'b0; en = 1'b1;
    goto(t0 + 60);
    chk("p2_valid_held", int'(valid), 1);
    chk("p2_sample_held", int'(sample), 'h811);
    goto(t0 + 156);
    chk("p2_err_before_overrun", int'(err), 0);
    goto(t0 + 157);
    chk("p2_err_overrun", int'(err), 1);
    chk("p2_sample_kept", int'(sample), 'h811);
    goto(t0 + 160); en = 1'b0;
    goto(t0 + 250);
    chk("p2_sample_still", int'(sample), 'h811);
    push('h811, t0 + 250); ready = 1'b1;
    goto(t0 + 251);
    chk("p2_valid_drop", int'(valid), 0);
    clear_err();

    // Short period: missed ticks flagged, bursts start only from IDLE.
    t0 = cyc; s0 = start_q.size(); period = 16'd30; en = 1'b1;
    push('h831, t0 + 57);
    push('h841, t0 + 119);
    push('h851, t0 + 181);
    goto(t0 + 130); en = 1'b0;
    goto(t0 + 190);
    chk("p3_err_miss", int'(err), 2);
    chk("p3_start_count", start_q.size() - s0, 12);
    chk("p3_burst2_start", start_at(s0 + 4) - t0, 63);
    clear_err();

    // Converter timeout, then recovery on the next tick.
    t0 = cyc; s0 = start_q.size(); period = 16'd99; mute = 1'b1; en = 1'b1;
    goto(t0 + 16);
    chk("p4_err_before_timeout", int'(err), 0);
    goto(t0 + 17);
    chk("p4_err_timeout", int'(err), 4);
    goto(t0 + 50); mute = 1'b0;
    push('h861, t0 + 157);
    goto(t0 + 160); en = 1'b0;
    chk("p4_err_sticky", int'(err), 4);
    chk("p4_restart", start_at(s0 + 1) - t0, 101);
    chk("p4_start_count", start_q.size() - s0, 5);
    clear_err();

    // rdy_i outside WAIT is ignored.
    rdy_force = 1'b1;
    goto(cyc + 3);
    t0 = cyc; s0 = start_q.size(); en = 1'b1;
    goto(t0 + 2); rdy_force = 1'b0;
    push('h871, t0 + 57);
    goto(t0 + 60); en = 1'b0;
    chk("p5_err", int'(err), 0);
    chk("p5_first_start", start_at(s0) - t0, 1);
    chk("p5_start_count", start_q.size() - s0, 4);

    // OSR_LOG2=0 instance: one conversion per sample.
    t0 = cyc; en0 = 1'b1;
    e0.sample = 'hFFF; e0.cyc = t0 + 15;
    exp0_q.push_back(e0);
    goto(t0 + 16);
    chk("p6_valid0_drop", int'(valid0), 0);
    goto(t0 + 30); en0 = 1'b0;
    chk("p6_sample0", int'(sample0), 'hFFF);
    chk("p6_err0", int'(err0), 0);

    // Asynchronous reset mid-WAIT with a held sample.
    t0 = cyc; ready = 1'b0; en = 1'b1;
    goto(t0 + 110);
    chk("p7_valid_before_rst", int'(valid), 1);
    chk("p7_sample_before_rst", int'(sample), 'h881);
    #2; rst = 1'b1;
    #1;
    chk("p7_rst_start", int'(start), 0);
    chk("p7_rst_valid", int'(valid), 0);
    chk("p7_rst_sample", int'(sample), 0);
    chk("p7_rst_err", int'(err), 0);
    ready = 1'b1;
    goto(t0 + 113);
    rst = 1'b0; s0 = start_q.size(); t0 = cyc;
    push('h801, t0 + 57);
    goto(t0 + 2);
    chk("p7_fresh_start", start_at(s0) - t0, 1);
    goto(t0 + 60); en = 1'b0;
    goto(t0 + 70);

    chk("sb_leftover", exp_q.size(), 0);
    chk("sb0_leftover", exp0_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
